scoot_world_sequencer: RTL and testbench

Sequencer that owns the grid world for a scootBot and steps it through a fixed-length run. It holds the WIDTH×HEIGHT item grid in registers and, once per step:
- collects the item under the bot;
- presents the four neighbour cells on the bot's sense inputs;
- waits a fixed number of cycles for the bot's motor outputs;
- moves the bot with wrap-around.

It sits between the grid storage/loader and a scootBot instance and reports position, steps and pickups to the bench or host.

---
 rtl/scoot_world_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_scoot_world_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/scoot_world_sequencer.sv
// -----------------------------------------------------------------------------
// scoot_world_sequencer
//
// Owns the WIDTH x HEIGHT item grid of a scootBot world and steps the bot
// through a fixed-length run.  Each step is SENSE (collect the item under the
// bot, register the four neighbour cells), WAIT (BOT_LATENCY cycles holding
// the sense outputs), then MOVE (sample the motors and update the position).
//
// Configuration macro: SCOOT_WRAP_EN
//   defined   : toroidal world, position and neighbour indices wrap around
//   undefined : bounded world, off-grid neighbours sense 0, moves clamp
//
// Ports
//   clock                    single clock, all state on posedge
//   resetN                   synchronous active-low reset
//   start                    begin a run (honoured in IDLE / DONE only)
//   loadEn/loadX/loadY/loadBit  grid write port (honoured only when busy=0)
//   mUp/mRight/mDown/mLeft   bot motor outputs, sampled in MOVE
//   lUp/lRight/lDown/lLeft   registered neighbour sense to the bot
//   posX/posY                bot position
//   stepCount                completed steps this run
//   pickCount                items collected this run (saturating)
//   pickPulse                one-cycle pulse per pickup
//   busy                     high in SENSE/WAIT/MOVE
//   done                     high in DONE
// -----------------------------------------------------------------------------
module scoot_world_sequencer #(
   parameter int WIDTH       = 10,
   parameter int HEIGHT      = 10,
   parameter int NUM_STEPS   = 100,
   parameter int BOT_LATENCY = 2
) (
   input  logic                                 clock,
   input  logic                                 resetN,
   input  logic                                 start,
   input  logic                                 loadEn,
   input  logic [$clog2(WIDTH)-1:0]             loadX,
   input  logic [$clog2(HEIGHT)-1:0]            loadY,
   input  logic                                 loadBit,
   input  logic                                 mUp,
   input  logic                                 mRight,
   input  logic                                 mDown,
   input  logic                                 mLeft,
   output logic                                 lUp,
   output logic                                 lRight,
   output logic                                 lDown,
   output logic                                 lLeft,
   output logic [$clog2(WIDTH)-1:0]             posX,
   output logic [$clog2(HEIGHT)-1:0]            posY,
   output logic [$clog2(NUM_STEPS+1)-1:0]       stepCount,
   output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pickCount,
   output logic                                 pickPulse,
   output logic                                 busy,
   output logic                                 done
);

   localparam int CELLS = WIDTH * HEIGHT;
   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int SW    = $clog2(NUM_STEPS + 1);
   localparam int PW    = $clog2(CELLS + 1);
   localparam int CW    = $clog2(BOT_LATENCY + 1);
   localparam int IW    = $clog2(CELLS);

   localparam logic [XW-1:0] X_MAX  = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT - 1);
   localparam logic [XW-1:0] X_MID  = XW'(WIDTH / 2);
   localparam logic [YW-1:0] Y_MID  = YW'(HEIGHT / 2);
   localparam logic [PW-1:0] PC_MAX = PW'(CELLS);

`ifdef SCOOT_WRAP_EN
   localparam logic WRAP = 1'b1;
`else
   localparam logic WRAP = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SENSE,
      S_WAIT,
      S_MOVE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CELLS-1:0]  grid_q, grid_d;
   logic [XW-1:0]     posX_q, posX_d;
   logic [YW-1:0]     posY_q, posY_d;
   logic [SW-1:0]     step_q, step_d;
   logic [PW-1:0]     pick_q, pick_d;
   logic              pulse_q, pulse_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              lUp_q, lUp_d;
   logic              lRight_q, lRight_d;
   logic              lDown_q, lDown_d;
   logic              lLeft_q, lLeft_d;
   logic [SW-1:0]     step_inc;
   logic [IW-1:0]     here_idx;

   // Step one cell along an axis.  At the grid edge the result either wraps
   // or stays put; in the bounded world the "stays put" value doubles as the
   // (gated-off) neighbour index, so one set of helpers serves both uses.
   function automatic logic [XW-1:0] x_plus(input logic [XW-1:0] x);
      return (x == X_MAX) ? (WRAP ? XW'(0) : X_MAX) : x + 1'b1;
   endfunction

   function automatic logic [XW-1:0] x_minus(input logic [XW-1:0] x);
      return (x == XW'(0)) ? (WRAP ? X_MAX : XW'(0)) : x - 1'b1;
   endfunction

   function automatic logic [YW-1:0] y_plus(input logic [YW-1:0] y);
      return (y == Y_MAX) ? (WRAP ? YW'(0) : Y_MAX) : y + 1'b1;
   endfunction

   function automatic logic [YW-1:0] y_minus(input logic [YW-1:0] y);
      return (y == YW'(0)) ? (WRAP ? Y_MAX : YW'(0)) : y - 1'b1;
   endfunction

   function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
      return IW'(int'(y) * WIDTH + int'(x));
   endfunction

   function automatic logic [PW-1:0] pick_sat_inc(input logic [PW-1:0] pc);
      return (pc == PC_MAX) ? pc : pc + 1'b1;
   endfunction

   assign step_inc = step_q + 1'b1;
   assign here_idx = cell_idx(posX_q, posY_q);

   always_comb begin
      state_d  = state_q;
      grid_d   = grid_q;
      posX_d   = posX_q;
      posY_d   = posY_q;
      step_d   = step_q;
      pick_d   = pick_q;
      pulse_d  = 1'b0;
      cnt_d    = cnt_q;
      lUp_d    = lUp_q;
      lRight_d = lRight_q;
      lDown_d  = lDown_q;
      lLeft_d  = lLeft_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // Range guard matters only for non-power-of-two grid sizes.
            if (loadEn && (loadX <= X_MAX) && (loadY <= Y_MAX)) begin
               grid_d[cell_idx(loadX, loadY)] = loadBit;
            end
            if (start) begin
               state_d = S_SENSE;
               posX_d  = X_MID;
               posY_d  = Y_MID;
               step_d  = '0;
               pick_d  = '0;
            end
         end

         S_SENSE: begin
            if (grid_q[here_idx]) begin
               grid_d[here_idx] = 1'b0;
               pick_d           = pick_sat_inc(pick_q);
               pulse_d          = 1'b1;
            end
            // Off-grid neighbours read 0 in the bounded world.
            lUp_d    = (WRAP || (posY_q != Y_MAX)) &&
                       grid_q[cell_idx(posX_q, y_plus(posY_q))];
            lRight_d = (WRAP || (posX_q != X_MAX)) &&
                       grid_q[cell_idx(x_plus(posX_q), posY_q)];
            lDown_d  = (WRAP || (posY_q != YW'(0))) &&
                       grid_q[cell_idx(posX_q, y_minus(posY_q))];
            lLeft_d  = (WRAP || (posX_q != XW'(0))) &&
                       grid_q[cell_idx(x_minus(posX_q), posY_q)];
            cnt_d    = CW'(BOT_LATENCY);
            state_d  = S_WAIT;
         end

         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) begin
               state_d = S_MOVE;
            end
         end

         S_MOVE: begin
            // Opposing motors on one axis cancel out.
            case ({mRight, mLeft})
               2'b10:   posX_d = x_plus(posX_q);
               2'b01:   posX_d = x_minus(posX_q);
               default: posX_d = posX_q;
            endcase
            case ({mUp, mDown})
               2'b10:   posY_d = y_plus(posY_q);
               2'b01:   posY_d = y_minus(posY_q);
               default: posY_d = posY_q;
            endcase
            step_d   = step_inc;
            lUp_d    = 1'b0;
            lRight_d = 1'b0;
            lDown_d  = 1'b0;
            lLeft_d  = 1'b0;
            state_d  = (step_inc == SW'(NUM_STEPS)) ? S_DONE : S_SENSE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q  <= S_IDLE;
         grid_q   <= '0;
         posX_q   <= X_MID;
         posY_q   <= Y_MID;
         step_q   <= '0;
         pick_q   <= '0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
         lUp_q    <= 1'b0;
         lRight_q <= 1'b0;
         lDown_q  <= 1'b0;
         lLeft_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grid_q   <= grid_d;
         posX_q   <= posX_d;
         posY_q   <= posY_d;
         step_q   <= step_d;
         pick_q   <= pick_d;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
         lUp_q    <= lUp_d;
         lRight_q <= lRight_d;
         lDown_q  <= lDown_d;
         lLeft_q  <= lLeft_d;
      end
   end

   assign lUp       = lUp_q;
   assign lRight    = lRight_q;
   assign lDown     = lDown_q;
   assign lLeft     = lLeft_q;
   assign posX      = posX_q;
   assign posY      = posY_q;
   assign stepCount = step_q;
   assign pickCount = pick_q;
   assign pickPulse = pulse_q;
   assign busy      = (state_q == S_SENSE) || (state_q == S_WAIT) ||
                      (state_q == S_MOVE);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_scoot_world_sequencer.sv
module tb_scoot_world_sequencer;

   localparam int LAT = 2;

   logic       clock = 1'b0;
   logic       resetN, start, loadEn, loadBit;
   logic [3:0] loadX, loadY;
   logic       mUp, mRight, mDown, mLeft;
   logic       lUp, lRight, lDown, lLeft;
   logic [3:0] posX, posY;
   logic [2:0] stepCount;
   logic [6:0] pickCount;
   logic       pickPulse, busy, done;

   int n_chk  = 0;
   int n_fail = 0;

   scoot_world_sequencer #(
      .WIDTH(10), .HEIGHT(10), .NUM_STEPS(6), .BOT_LATENCY(LAT)
   ) dut (
      .clock(clock), .resetN(resetN), .start(start), .loadEn(loadEn),
      .loadX(loadX), .loadY(loadY), .loadBit(loadBit),
      .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
      .lUp(lUp), .lRight(lRight), .lDown(lDown), .lLeft(lLeft),
      .posX(posX), .posY(posY), .stepCount(stepCount), .pickCount(pickCount),
      .pickPulse(pickPulse), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One record per bot step: motors {U,R,D,L}, expected sense {U,R,D,L},
   // expected pickup, position after MOVE, pickCount after SENSE, stepCount
   // and done after MOVE, plus a side stimulus applied while busy.
   typedef struct {
      logic [3:0] mot;
      logic [3:0] el;
      logic       ep;
      int         ex, ey, epc, esc;
      logic       ed;
      int         side;   // 0 none, 1 load (0,0), 2 start, 3 load (5,6)
   } step_t;

   step_t tbl [20];

   function automatic step_t mk(input logic [3:0] mot, input logic [3:0] el,
                                input logic ep, input int ex, input int ey,
                                input int epc, input int esc, input logic ed,
                                input int side);
      step_t s;
      s.mot = mot; s.el = el; s.ep = ep; s.ex = ex; s.ey = ey;
      s.epc = epc; s.esc = esc; s.ed = ed; s.side = side;
      return s;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic load_cell(input int x, input int y);
      loadEn = 1'b1; loadX = 4'(x); loadY = 4'(y); loadBit = 1'b1;
      tick();
      loadEn = 1'b0;
   endtask

   task automatic start_run(input logic with_load, input int x, input int y);
      start = 1'b1;
      if (with_load) begin
         loadEn = 1'b1; loadX = 4'(x); loadY = 4'(y); loadBit = 1'b1;
      end
      tick();
      start = 1'b0; loadEn = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_posX", posX, 5);
      chk("start_posY", posY, 5);
      chk("start_stepCount", stepCount, 0);
      chk("start_pickCount", pickCount, 0);
   endtask

   task automatic do_step(input int i);
      step_t s;
      s = tbl[i];
      // Wrong motor values until the MOVE cycle: only the MOVE edge counts.
      {mUp, mRight, mDown, mLeft} = ~s.mot;
      tick();  // SENSE edge
      chk($sformatf("pickPulse[%0d]", i), pickPulse, s.ep);
      chk($sformatf("pickCount[%0d]", i), pickCount, s.epc);
      chk($sformatf("sense[%0d]", i), {lUp, lRight, lDown, lLeft}, s.el);
      case (s.side)
         1: begin loadEn = 1'b1; loadX = 4'd0; loadY = 4'd0; loadBit = 1'b1; end
         2: start = 1'b1;
         3: begin loadEn = 1'b1; loadX = 4'd5; loadY = 4'd6; loadBit = 1'b1; end
         default: ;
      endcase
      for (int k = 0; k < LAT; k++) begin
         tick();  // WAIT edges
         loadEn = 1'b0; start = 1'b0;
         chk($sformatf("sense_hold[%0d]", i), {lUp, lRight, lDown, lLeft}, s.el);
         chk($sformatf("pulse_len[%0d]", i), pickPulse, 0);
      end
      {mUp, mRight, mDown, mLeft} = s.mot;
      tick();  // MOVE edge
      chk($sformatf("posX[%0d]", i), posX, s.ex);
      chk($sformatf("posY[%0d]", i), posY, s.ey);
      chk($sformatf("stepCount[%0d]", i), stepCount, s.esc);
      chk($sformatf("done[%0d]", i), done, s.ed);
      chk($sformatf("sense_clr[%0d]", i), {lUp, lRight, lDown, lLeft}, 0);
   endtask

   initial begin
      // Scenario B: items at (5,5),(5,6),(5,0); bot drives up.
      tbl[0]  = mk(4'b1000, 4'b1000, 1, 5, 6, 1, 1, 0, 0);
      tbl[1]  = mk(4'b1000, 4'b0000, 1, 5, 7, 2, 2, 0, 0);
      tbl[2]  = mk(4'b1000, 4'b0000, 0, 5, 8, 2, 3, 0, 0);
      tbl[3]  = mk(4'b1000, 4'b0000, 0, 5, 9, 2, 4, 0, 0);
`ifdef SCOOT_WRAP_EN
      tbl[4]  = mk(4'b1000, 4'b1000, 0, 5, 0, 2, 5, 0, 0);
      tbl[5]  = mk(4'b1000, 4'b0000, 1, 5, 1, 3, 6, 1, 0);
`else
      tbl[4]  = mk(4'b1000, 4'b0000, 0, 5, 9, 2, 5, 0, 0);
      tbl[5]  = mk(4'b1000, 4'b0000, 0, 5, 9, 2, 6, 1, 0);
`endif
      // Scenario C: item at (9,5); bot drives left.
      tbl[6]  = mk(4'b0001, 4'b0000, 0, 4, 5, 0, 1, 0, 0);
      tbl[7]  = mk(4'b0001, 4'b0000, 0, 3, 5, 0, 2, 0, 0);
      tbl[8]  = mk(4'b0001, 4'b0000, 0, 2, 5, 0, 3, 0, 0);
      tbl[9]  = mk(4'b0001, 4'b0000, 0, 1, 5, 0, 4, 0, 0);
      tbl[10] = mk(4'b0001, 4'b0000, 0, 0, 5, 0, 5, 0, 0);
`ifdef SCOOT_WRAP_EN
      tbl[11] = mk(4'b0001, 4'b0001, 0, 9, 5, 0, 6, 1, 0);
`else
      tbl[11] = mk(4'b0001, 4'b0000, 0, 0, 5, 0, 6, 1, 0);
`endif
      // Scenario D: opposing motors, busy loads and busy start ignored.
      tbl[12] = mk(4'b0101, 4'b0000, 1, 5, 5, 1, 1, 0, 1);
      tbl[13] = mk(4'b1010, 4'b0000, 0, 5, 5, 1, 2, 0, 2);
      tbl[14] = mk(4'b0000, 4'b0000, 0, 5, 5, 1, 3, 0, 3);
      tbl[15] = mk(4'b0000, 4'b0000, 0, 5, 5, 1, 4, 0, 0);
      tbl[16] = mk(4'b0000, 4'b0000, 0, 5, 5, 1, 5, 0, 0);
      tbl[17] = mk(4'b0000, 4'b0000, 0, 5, 5, 1, 6, 1, 0);
      // Scenario E: items at (5,5),(6,5),(7,5),(5,6); bot drives right.
      tbl[18] = mk(4'b0100, 4'b1100, 1, 6, 5, 1, 1, 0, 0);
      tbl[19] = mk(4'b0100, 4'b0100, 1, 7, 5, 2, 2, 0, 0);

      resetN = 1'b0; start = 1'b0; loadEn = 1'b0; loadBit = 1'b0;
      loadX = 4'd0; loadY = 4'd0;
      {mUp, mRight, mDown, mLeft} = 4'b0000;
      tick(); tick();
      chk("rst_posX", posX, 5);
      chk("rst_posY", posY, 5);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stepCount", stepCount, 0);
      chk("rst_pickCount", pickCount, 0);
      chk("rst_pickPulse", pickPulse, 0);
      chk("rst_sense", {lUp, lRight, lDown, lLeft}, 0);
      resetN = 1'b1;

      load_cell(5, 5); load_cell(5, 6); load_cell(5, 0);
      start_run(1'b0, 0, 0);
      for (int i = 0; i < 6; i++) do_step(i);
      tick(); tick(); tick();
      chk("done_hold", done, 1);
      chk("done_hold_busy", busy, 0);
      chk("done_hold_step", stepCount, 6);
      chk("done_hold_posY", posY, tbl[5].ey);

      load_cell(9, 5);
      start_run(1'b0, 0, 0);
      for (int i = 6; i < 12; i++) do_step(i);

      start_run(1'b1, 5, 5);
      for (int i = 12; i < 18; i++) do_step(i);

      load_cell(5, 5); load_cell(6, 5); load_cell(7, 5); load_cell(5, 6);
      start_run(1'b0, 0, 0);
      for (int i = 18; i < 20; i++) do_step(i);
      {mUp, mRight, mDown, mLeft} = 4'b0100;
      tick();  // third SENSE at (7,5)
      chk("e_pickPulse", pickPulse, 1);
      chk("e_pickCount", pickCount, 3);
      chk("e_posX", posX, 7);
      tick();  // mid-WAIT
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_posX", posX, 5);
      chk("mrst_posY", posY, 5);
      chk("mrst_pickCount", pickCount, 0);
      chk("mrst_stepCount", stepCount, 0);
      chk("mrst_sense", {lUp, lRight, lDown, lLeft}, 0);
      {mUp, mRight, mDown, mLeft} = 4'b0000;
      start_run(1'b0, 0, 0);
      tick();  // SENSE at (5,5): (5,6) would read 1 had the grid survived
      chk("mrst_grid_pick", pickPulse, 0);
      chk("mrst_grid_sense", {lUp, lRight, lDown, lLeft}, 0);
      chk("mrst_grid_pc", pickCount, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
